permute_pi: RTL and testbench
=============================

// Module: permute_pi
// PURPOSE
//  Pi-permutation stage of the 5x5x64 state-matrix pipeline; sits directly upstream of the
//  revaluate (chi) stage and produces the matrix that stage consumes.
//  Takes a start/ready handshake, snapshots the full state and rewrites it cell by cell.
//  The gather rule is out(i,j,k) = in((i+3j) mod 5, i, k); page k is never changed.
//  Cell address is addr(i,j,k) = k*25 + j*5 + i (i = row, j = column, k = page), the same mapping as chi.
// PARAMETERS
//  NUM_ROW     5    rows per page (i range)
//  NUM_COLUMN  5    columns per page (j range)
//  NUM_PAGE    64   pages (k range, lane depth)
//  NUM_CELLS   NUM_ROW*NUM_COLUMN*NUM_PAGE (derived, 1600)
// PORTS
//  clk       in   1          rising-edge clock
//  rst       in   1          synchronous, active-high reset
//  start     in   1          request; sampled only while ready=1
//  data_in   in   NUM_CELLS  input matrix; captured on the accepting edge only
//  ready     out  1          1 in IDLE only
//  busy      out  1          1 in RUN
//  done      out  1          one-cycle pulse; data_out is complete while it is high
//  data_out  out  NUM_CELLS  permuted matrix register; held until the next run overwrites it
// BEHAVIOUR
//  - FSM states: IDLE -> RUN -> DONE -> IDLE. All outputs are registered or decoded from state.
//  - Reset (edge with rst=1, in any state):
//    - state goes to IDLE; the i, j and k counters go to 0; snapshot and data_out go to 0.
//    - Output values: done=0, busy=0, ready=1.
//  - IDLE: on an edge with start=1:
//    - data_in is copied into an internal snapshot register.
//    - The counters are cleared and state goes to RUN.
//  - RUN: each edge writes one cell and then advances the counters.
//    - Write: data_out[addr(i,j,k)] <= snap[addr((i+3j)%5, i, k)].
//    - Count order: i counts 0..4 and wraps, which increments j.
//    - j counts 0..4 and wraps, which increments k; k counts 0..63.
//    - The edge that writes (4,4,63) moves state to DONE and wraps all counters to 0.
//  - Latency: start-accept edge E0, write edges E1..E1600.
//    - done=1 during the cycle after E1600; E1601 returns to IDLE.
//    - Total: 1600 cycles from accept to done. Throughput is one matrix per 1602 cycles.
//  - Index arithmetic: (i+3j) is at most 16 and needs 5 bits; mod 5 uses a compare/subtract chain, no divider.
//  - start while in RUN or DONE is ignored; it is not queued.
//  - data_in changes after the accept edge have no effect, because only the snapshot is read.
//  - data_out is partially updated during RUN. The consumer may sample it only while done=1 or later in IDLE.
//  - rst has priority over start when both are high on the same edge.
//  - rst during RUN aborts the run: no done pulse, data_out=0.
// CONFIGURATION
//  LANE_PARALLEL_EN
//  - Defined:
//    - The k counter is removed; each RUN edge writes all 64 pages of cell (i,j) in parallel.
//    - Write rule: out(i,j,*) <= snap((i+3j)%5, i, *).
//    - The RUN phase lasts 25 edges, so done is seen 25 cycles after the accept edge.
//  - Undefined: bit-serial operation as described above, 1600 write cycles. The result is bit-identical in both modes.
// TESTING
//  1. Assert rst for 2 cycles, then release.
//     -> ready=1, busy=0, done=0, data_out=0; start held low -> the outputs stay unchanged.
//  2. Single bit data_in[176] (cell 1,0,7), pulse start.
//     -> done exactly 1600 cycles later (25 with the macro); data_out has only bit 185 (cell 0,2,7) set.
//  3. Single bit data_in[1592] (cell 2,3,63).
//     -> only data_out[1593] (cell 3,3,63) set; data_in[0] alone -> only data_out[0] set.
//  4. All-ones data_in -> data_out all ones.
//     Random data_in vs reference model -> match on all 1600 bits; run back-to-back 100 matrices.
//  5. Pulse start again 10 cycles into RUN and change data_in.
//     -> a single done pulse at the original time; result reflects the first data_in only.
//  6. Assert rst 500 cycles into RUN.
//     -> the next cycle shows IDLE, data_out=0, no done; a fresh start then completes normally.

Source files
------------

// File: rtl/permute_pi.sv
// permute_pi: pi-permutation stage, out(i,j,k) = in((i+3j) mod 5, i, k).
// Define LANE_PARALLEL_EN to write all pages of one (i,j) cell per cycle.
module permute_pi #(
  parameter int NUM_ROW    = 5,
  parameter int NUM_COLUMN = 5,
  parameter int NUM_PAGE   = 64,
  parameter int NUM_CELLS  = NUM_ROW * NUM_COLUMN * NUM_PAGE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_CELLS-1:0] data_in,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_CELLS-1:0] data_out
);

  localparam int PAGE = NUM_ROW * NUM_COLUMN;
  localparam int AW   = $clog2(NUM_CELLS);
  localparam int RW   = $clog2(NUM_ROW);
  localparam int CW   = $clog2(NUM_COLUMN);

  localparam logic [RW-1:0] I_MAX = RW'(NUM_ROW - 1);
  localparam logic [CW-1:0] J_MAX = CW'(NUM_COLUMN - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [NUM_CELLS-1:0] snap;
  logic [RW-1:0]        i;
  logic [CW-1:0]        j;
  logic [4:0]           sum;
  logic [4:0]           red;
  logic [RW-1:0]        src_row;
  logic [AW-1:0]        dst_base;
  logic [AW-1:0]        src_base;
  logic                 last;

`ifndef LANE_PARALLEL_EN
  localparam int KW = $clog2(NUM_PAGE);
  localparam logic [KW-1:0] K_MAX = KW'(NUM_PAGE - 1);

  logic [KW-1:0] k;
  logic [AW-1:0] page_base;

  assign page_base = AW'(k) * AW'(PAGE);
  assign last = (i == I_MAX) && (j == J_MAX) && (k == K_MAX);
`else
  assign last = (i == I_MAX) && (j == J_MAX);
`endif

  // (i + 3j) tops out at 16, so three compare/subtract steps cover mod 5
  always_comb begin
    sum = 5'(i) + 5'(j) + 5'(j) + 5'(j);
    red = sum;
    if (sum >= 5'd15) begin
      red = sum - 5'd15;
    end else if (sum >= 5'd10) begin
      red = sum - 5'd10;
    end else if (sum >= 5'd5) begin
      red = sum - 5'd5;
    end
    src_row = RW'(red);
  end

  // source column is the destination row
  assign dst_base = AW'(j) * AW'(NUM_ROW) + AW'(i);
  assign src_base = AW'(i) * AW'(NUM_ROW) + AW'(src_row);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (last) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap     <= '0;
      data_out <= '0;
      i        <= '0;
      j        <= '0;
`ifndef LANE_PARALLEL_EN
      k        <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            snap <= data_in;
            i    <= '0;
            j    <= '0;
`ifndef LANE_PARALLEL_EN
            k    <= '0;
`endif
          end
        end
        RUN: begin
`ifdef LANE_PARALLEL_EN
          for (int p = 0; p < NUM_PAGE; p++) begin
            data_out[AW'(p * PAGE) + dst_base] <=
              snap[AW'(p * PAGE) + src_base];
          end
`else
          data_out[page_base + dst_base] <=
            snap[page_base + src_base];
`endif
          if (i == I_MAX) begin
            i <= '0;
            if (j == J_MAX) begin
              j <= '0;
`ifndef LANE_PARALLEL_EN
              k <= (k == K_MAX) ? '0 : k + 1'b1;
`endif
            end else begin
              j <= j + 1'b1;
            end
          end else begin
            i <= i + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_permute_pi.sv
// tb_permute_pi: scoreboard bench for permute_pi.
// Build with LANE_PARALLEL_EN to match a lane-parallel DUT.
module tb_permute_pi;

  localparam int N = 1600;
`ifdef LANE_PARALLEL_EN
  localparam int RUN_LEN = 25;
  localparam int N_RAND  = 100;
  localparam int ABORT   = 12;
`else
  localparam int RUN_LEN = 1600;
  localparam int N_RAND  = 20;
  localparam int ABORT   = 500;
`endif

  typedef struct {
    logic [N-1:0] data;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] data_in;
  logic         ready;
  logic         busy;
  logic         done;
  logic [N-1:0] data_out;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  exp_t cur;

  permute_pi dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .data_in  (data_in),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [N-1:0] model(input logic [N-1:0] x);
    logic [N-1:0] y = '0;
    for (int k = 0; k < 64; k++)
      for (int j = 0; j < 5; j++)
        for (int i = 0; i < 5; i++)
          y[k*25 + j*5 + i] = x[k*25 + i*5 + ((i + 3*j) % 5)];
    return y;
  endfunction

  function automatic logic [N-1:0] one_hot(input int b);
    logic [N-1:0] v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] rand_vec();
    logic [N-1:0] v = '0;
    for (int w = 0; w < N/32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk_val(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d (cyc %0d)", nm, a, e, cyc);
    end
  endtask

  task automatic chk_vec(input string nm, input logic [N-1:0] a,
                         input logic [N-1:0] e);
    logic [N-1:0] x;
    int first = -1;
    total++;
    x = a ^ e;
    if (x != '0) begin
      bad++;
      for (int b = N - 1; b >= 0; b--) if (x[b]) first = b;
      $display("FAIL %s got %0d wrong bits, first at %0d got=%b want=%b, ones got=%0d want=%0d",
               nm, $countones(x), first, a[first], e[first],
               $countones(a), $countones(e));
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done got done=1 want=0 (cyc %0d)", cyc);
      end else begin
        cur = sb.pop_front();
        chk_val("done_time", cyc, cur.due);
        chk_vec("data_out", data_out, cur.data);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout got ready=0 want=1 (cyc %0d)", cyc);
    end
  endtask

  // called at a negedge; accept happens on the following posedge
  task automatic launch(input logic [N-1:0] d, input logic [N-1:0] e,
                        input bit push);
    exp_t x;
    wait_ready();
    data_in = d;
    start   = 1'b1;
    x.data  = e;
    x.due   = cyc + 1 + RUN_LEN;
    if (push) sb.push_back(x);
    @(negedge clk);
    start = 1'b0;
    chk_val("busy_after_accept", int'(busy), 1);
    chk_val("ready_in_run", int'(ready), 0);
  endtask

  initial begin
    logic [N-1:0] d;
    int n;
    rst     = 1'b1;
    start   = 1'b0;
    data_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int c = 0; c < 3; c++) begin
      chk_val("reset_ready", int'(ready), 1);
      chk_val("reset_busy", int'(busy), 0);
      chk_val("reset_done", int'(done), 0);
      chk_vec("reset_data_out", data_out, '0);
      @(negedge clk);
    end

    launch(one_hot(176), one_hot(185), 1'b1);
    launch(one_hot(1592), one_hot(1593), 1'b1);
    launch(one_hot(0), one_hot(0), 1'b1);
    launch('1, '1, 1'b1);

    for (int r = 0; r < N_RAND; r++) begin
      d = rand_vec();
      launch(d, model(d), 1'b1);
    end

    d = rand_vec();
    launch(d, model(d), 1'b1);
    repeat (9) @(negedge clk);
    data_in = ~d;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    data_in = rand_vec();

    d = rand_vec();
    launch(d, '0, 1'b0);
    repeat (ABORT - 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_val("abort_ready", int'(ready), 1);
    chk_val("abort_busy", int'(busy), 0);
    chk_val("abort_done", int'(done), 0);
    chk_vec("abort_data_out", data_out, '0);
    rst = 1'b0;

    d = rand_vec();
    launch(d, model(d), 1'b1);

    n = 0;
    while (sb.size() != 0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout got pending=%0d want=0", sb.size());
    end
    repeat (5) @(negedge clk);
    chk_vec("data_out_held", data_out, model(d));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
